// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control-unit front end: control-word bit map,
// microcode address width and the run/halt state encoding.
package control_sequencer_pkg;

  localparam int unsigned UC_ADDR_W = 9;

  localparam int unsigned BIT_HLT = 15;
  localparam int unsigned BIT_MI  = 14;
  localparam int unsigned BIT_RI  = 13;
  localparam int unsigned BIT_RO  = 12;
  localparam int unsigned BIT_IO  = 11;
  localparam int unsigned BIT_II  = 10;
  localparam int unsigned BIT_AI  = 9;
  localparam int unsigned BIT_AO  = 8;
  localparam int unsigned BIT_EO  = 7;
  localparam int unsigned BIT_SU  = 6;
  localparam int unsigned BIT_BI  = 5;
  localparam int unsigned BIT_OI  = 4;
  localparam int unsigned BIT_CE  = 3;
  localparam int unsigned BIT_CO  = 2;
  localparam int unsigned BIT_J   = 1;
  localparam int unsigned BIT_FI  = 0;

  typedef enum logic {
    RUN_ACTIVE = 1'b0,
    RUN_HALTED = 1'b1
  } run_state_e;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// T-step counter: advances on en, returns to 0 on clr or after the last step.
module step_counter #(
  parameter int unsigned NUM_STEPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] step
);

  logic [2:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (en) begin
      if (clr || step_q == 3'(NUM_STEPS - 1)) begin
        step_d = '0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Control-unit front end: IR, ZF/CF flags, T-step counter and halt latch;
// forms the microcode address and gates the returned control word.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned EARLY_END = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [7:0]           bus_in,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic [15:0]          uc_data,
  output logic [UC_ADDR_W-1:0] uc_addr,
  output logic [15:0]          ctrl,
  output logic [3:0]           ir_operand,
  output logic [2:0]           step,
  output logic                 zf,
  output logic                 cf,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  run_state_e       state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic             zf_q, zf_d, cf_q, cf_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             step_en, early_end, last_step;

  // Early end looks at raw uc_data so a zero ROM word during fetch never ends it.
  assign early_end = (EARLY_END != 0) && (step >= 3'd2) && (uc_data == '0);
  assign last_step = (step == 3'(NUM_STEPS - 1));

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    retired_d = retired_q;
    step_en   = 1'b0;
    ctrl      = uc_data;
    unique case (state_q)
      RUN_ACTIVE: begin
        if (run) begin
          if (uc_data[BIT_II]) ir_d = bus_in;
          if (uc_data[BIT_FI]) begin
            zf_d = alu_zero;
            cf_d = alu_carry;
          end
          if (uc_data[BIT_HLT]) begin
            state_d = RUN_HALTED;
          end else begin
            step_en = 1'b1;
            if (last_step || early_end) retired_d = retired_q + CNT_W'(1);
          end
        end
      end
      RUN_HALTED: ctrl = '0;
      default:    ctrl = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN_ACTIVE;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
      retired_q <= retired_d;
    end
  end

  step_counter #(
    .NUM_STEPS(NUM_STEPS)
  ) u_step_counter (
    .clk  (clk),
    .reset(reset),
    .en   (step_en),
    .clr  (early_end),
    .step (step)
  );

  assign uc_addr    = {zf_q, cf_q, ir_q[7:4], step};
  assign ir_operand = ir_q[3:0];
  assign zf         = zf_q;
  assign cf         = cf_q;
  assign halted     = (state_q == RUN_HALTED);
  assign retired    = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; a second instance with EARLY_END=0
// sees an all-zero ROM to show the full 8-step wrap.
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000;
  localparam logic [15:0] MI  = 16'h4000;
  localparam logic [15:0] RO  = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800;
  localparam logic [15:0] II  = 16'h0400;
  localparam logic [15:0] AI  = 16'h0200;
  localparam logic [15:0] EO  = 16'h0080;
  localparam logic [15:0] BI  = 16'h0020;
  localparam logic [15:0] CE  = 16'h0008;
  localparam logic [15:0] CO  = 16'h0004;
  localparam logic [15:0] FI  = 16'h0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b1;
  logic [7:0]  bus_in = '0;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic [15:0] uc_data = '0;
  logic [8:0]  uc_addr;
  logic [15:0] ctrl;
  logic [3:0]  ir_operand;
  logic [2:0]  step;
  logic        zf, cf, halted;
  logic [15:0] retired;

  logic [15:0] uc_data_ne = '0;
  logic [8:0]  uc_addr_ne;
  logic [15:0] ctrl_ne;
  logic [3:0]  ir_operand_ne;
  logic [2:0]  step_ne;
  logic        zf_ne, cf_ne, halted_ne;
  logic [15:0] retired_ne;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(8), .EARLY_END(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .bus_in(bus_in),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .uc_data(uc_data),
    .uc_addr(uc_addr), .ctrl(ctrl), .ir_operand(ir_operand), .step(step),
    .zf(zf), .cf(cf), .halted(halted), .retired(retired)
  );

  control_sequencer #(.NUM_STEPS(8), .EARLY_END(0), .CNT_W(16)) dut_ne (
    .clk(clk), .reset(reset), .run(run), .bus_in(bus_in),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .uc_data(uc_data_ne),
    .uc_addr(uc_addr_ne), .ctrl(ctrl_ne), .ir_operand(ir_operand_ne), .step(step_ne),
    .zf(zf_ne), .cf(cf_ne), .halted(halted_ne), .retired(retired_ne)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b1;
    bus_in = 8'hA5;
    alu_zero = 1'b1;
    alu_carry = 1'b1;
    uc_data = HLT | II | FI;
    tick();
    tick();
    checks++; if (uc_addr !== 9'h000) begin errors++; $display("FAIL reset_uc_addr: got %h expected %h", uc_addr, 9'h000); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    checks++; if (ir_operand !== 4'h0) begin errors++; $display("FAIL reset_ir_operand: got %h expected 0", ir_operand); end
    checks++; if ({zf, cf, halted} !== 3'b000) begin errors++; $display("FAIL reset_flags_halt: got %b expected 000", {zf, cf, halted}); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if (ctrl !== (HLT | II | FI)) begin errors++; $display("FAIL reset_ctrl_pass: got %h expected %h", ctrl, HLT | II | FI); end
    reset = 1'b0;
    uc_data = '0;
  endtask

  task automatic test_fetch();
    do_reset();
    uc_data = MI | CO;
    tick();
    checks++; if (step !== 3'd1) begin errors++; $display("FAIL fetch_step1: got %0d expected 1", step); end
    uc_data = RO | II | CE;
    bus_in = 8'h1E;
    tick();
    checks++; if (uc_addr !== 9'b00_0001_010) begin errors++; $display("FAIL fetch_uc_addr: got %b expected %b", uc_addr, 9'b00_0001_010); end
    checks++; if (ir_operand !== 4'hE) begin errors++; $display("FAIL fetch_operand: got %h expected e", ir_operand); end
    uc_data = 16'h0000;
    tick();
    checks++; if (step !== 3'd0 || retired !== 16'd1) begin errors++; $display("FAIL fetch_end: got step=%0d retired=%0d expected step=0 retired=1", step, retired); end
  endtask

  task automatic test_early_end();
    logic [15:0] prog [4];
    logic [2:0]  exp_e [4];
    logic [2:0]  exp_ne [8];
    prog   = '{MI | CO, RO | II | CE, AI, 16'h0000};
    exp_e  = '{3'd1, 3'd2, 3'd3, 3'd0};
    exp_ne = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    uc_data_ne = '0;
    bus_in = 8'h20;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      uc_data = (i < 4) ? prog[i] : (MI | CO);
      tick();
      if (i < 4) begin
        checks++; if (step !== exp_e[i]) begin errors++; $display("FAIL early_step[%0d]: got %0d expected %0d", i, step, exp_e[i]); end
      end
      checks++; if (step_ne !== exp_ne[i]) begin errors++; $display("FAIL noearly_step[%0d]: got %0d expected %0d", i, step_ne, exp_ne[i]); end
      if (i == 3) begin
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL early_retired: got %0d expected 1", retired); end
      end
      if (i == 6) begin
        checks++; if (retired_ne !== 16'd0) begin errors++; $display("FAIL noearly_retired_pre: got %0d expected 0", retired_ne); end
      end
    end
    checks++; if (retired_ne !== 16'd1) begin errors++; $display("FAIL noearly_retired: got %0d expected 1", retired_ne); end
  endtask

  task automatic test_flags();
    logic [15:0] prog [5];
    prog = '{MI | CO, RO | II | CE, MI | IO, RO | BI, EO | AI | FI};
    do_reset();
    bus_in = 8'h2F;
    for (int i = 0; i < 5; i++) begin
      uc_data = prog[i];
      alu_carry = (i == 4);
      alu_zero = (i != 4);
      tick();
    end
    alu_carry = 1'b0;
    alu_zero = 1'b1;
    checks++; if (cf !== 1'b1 || zf !== 1'b0) begin errors++; $display("FAIL flags_capture: got zf=%b cf=%b expected zf=0 cf=1", zf, cf); end
    checks++; if (step !== 3'd5) begin errors++; $display("FAIL flags_step: got %0d expected 5", step); end
    uc_data = 16'h0000;
    tick();
    uc_data = MI | CO;
    tick();
    uc_data = RO | II | CE;
    bus_in = 8'h73;
    tick();
    checks++; if (uc_addr[7] !== 1'b1) begin errors++; $display("FAIL jc_cf_bit: got %b expected 1", uc_addr[7]); end
    checks++; if (uc_addr !== 9'h0BA) begin errors++; $display("FAIL jc_uc_addr: got %h expected 0ba", uc_addr); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL jc_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_halt();
    uc_data = HLT;
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
    for (int i = 0; i < 20; i++) begin
      uc_data = 16'($urandom) | II | FI | HLT;
      bus_in = 8'($urandom);
      alu_zero = 1'($urandom);
      alu_carry = 1'($urandom);
      checks++; if (ctrl !== 16'h0000) begin errors++; $display("FAIL halt_ctrl[%0d]: got %h expected 0000", i, ctrl); end
      tick();
      checks++; if (step !== 3'd2 || uc_addr !== 9'h0BA || halted !== 1'b1 || retired !== 16'd1) begin
        errors++;
        $display("FAIL halt_frozen[%0d]: got step=%0d uc_addr=%h halted=%b retired=%0d expected step=2 uc_addr=0ba halted=1 retired=1",
                 i, step, uc_addr, halted, retired);
      end
    end
    do_reset();
    checks++; if (halted !== 1'b0 || step !== 3'd0 || uc_addr !== 9'h000 || retired !== 16'd0) begin
      errors++;
      $display("FAIL halt_reset: got halted=%b step=%0d uc_addr=%h retired=%0d expected 0 0 000 0", halted, step, uc_addr, retired);
    end
  endtask

  task automatic test_run_reset();
    logic [15:0] prog [5];
    prog = '{MI | CO, RO | II | CE, 16'h0000, MI | CO, RO | II | CE};
    do_reset();
    bus_in = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      uc_data = prog[i];
      tick();
    end
    checks++; if (uc_addr !== 9'h02A || retired !== 16'd1) begin errors++; $display("FAIL pause_setup: got uc_addr=%h retired=%0d expected 02a 1", uc_addr, retired); end
    run = 1'b0;
    uc_data = RO | II | CE | FI;
    bus_in = 8'hFF;
    alu_zero = 1'b1;
    alu_carry = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (step !== 3'd2 || uc_addr !== 9'h02A || ir_operand !== 4'hA) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got step=%0d uc_addr=%h operand=%h expected 2 02a a", i, step, uc_addr, ir_operand);
      end
      checks++; if (ctrl !== 16'h1409) begin errors++; $display("FAIL pause_ctrl[%0d]: got %h expected 1409", i, ctrl); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (step !== 3'd0 || uc_addr !== 9'h000 || retired !== 16'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL pause_reset: got step=%0d uc_addr=%h retired=%0d halted=%b expected 0 000 0 0", step, uc_addr, retired, halted);
    end
    run = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_early_end();
    test_flags();
    test_halt();
    test_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
